round_key_buffer: RTL and testbench
===================================

# round_key_buffer

Parametrised round-key store and sequencer between the byte-serial key expansion datapath and the encrypt/decrypt cores. It captures every round key as the expansion streams it out, one bus beat per cycle. It then replays the full key set on a valid/ready stream in forward order for encryption or reverse order for decryption, repeatedly, without re-running the expansion. Bus width, key width and key count are parameters, so one block serves 8-bit and 32-bit datapaths and AES-128/192/256 key counts.

## Interface
- KEY_W, 128, width of one round key; must be a multiple of BUS_W
- BUS_W, 8, beat width on both input and output buses (8 or 32)
- NUM_KEYS, 11, number of round keys stored (11/13/15); BEATS = KEY_W/BUS_W per key
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  pulse: discard stored keys, begin load phase
- in_valid  in  1  key expansion beat present on in_data
- in_data  in  BUS_W  round-key beat, most-significant beat of each key first, key 0 first
- rd_start  in  1  pulse: begin a replay of all keys
- rd_dir  in  1  sampled with rd_start: 0 = key 0..NUM_KEYS-1, 1 = key NUM_KEYS-1..0
- out_ready  in  1  consumer accepts beat
- out_valid  out  1  out_data valid
- out_data  out  BUS_W  round-key beat, most-significant beat first within each key
- out_key_idx  out  clog2(NUM_KEYS)  index of key currently on out_data
- out_last  out  1  high with final beat of each key
- load_done  out  1  full key set stored, replay permitted
- busy  out  1  high in LOAD or STREAM
- err  out  1  sticky protocol error, cleared only by rst or start

## Operation
- Storage: NUM_KEYS*BEATS entries of BUS_W, addressed key*BEATS + beat.
- States: IDLE, LOAD, READY, STREAM.
- IDLE: default after reset; in_valid ignored and sets err; rd_start sets err.
- start (any state): write pointer <- 0, load_done <- 0, err <- 0, out_valid <- 0, state -> LOAD. Aborts a replay in progress.
- LOAD: each cycle with in_valid writes in_data to entry wr_ptr, wr_ptr++. The write of entry NUM_KEYS*BEATS-1 moves state to READY, load_done <- 1. rd_start in LOAD sets err and is ignored.
- READY: rd_start latches rd_dir, key index <- 0 (forward) or NUM_KEYS-1 (reverse), beat <- 0, state -> STREAM. in_valid in READY sets err; data is not written.
- STREAM: out_data = entry (key_idx*BEATS + beat). A beat transfers when out_valid && out_ready. On transfer, beat++. At beat BEATS-1, beat <- 0 and key_idx steps +1 (forward) or -1 (reverse). The transfer of the last beat of the final key (NUM_KEYS-1 forward, 0 reverse) ends the replay and returns state -> READY. Keys are retained; further rd_start replays are allowed.
- rd_start during STREAM is ignored and sets err. in_valid during STREAM sets err.
- out_last = out_valid && beat == BEATS-1.
- Simultaneous start and rd_start: start wins; rd_start is ignored without setting err.

## Timing
- Reset values: out_valid 0, out_data 0, out_key_idx 0, out_last 0, load_done 0, busy 0, err 0, state IDLE. Storage contents are not reset.
- start to LOAD: 1 cycle; the first in_valid accepted is the cycle after start.
- Load: NUM_KEYS*BEATS in_valid cycles. load_done rises the cycle after the last write.
- rd_start to out_valid: 1 cycle. out_data/out_key_idx/out_last are registered.
- Throughput is 1 beat/cycle with out_ready held high. Full replay takes NUM_KEYS*BEATS cycles after out_valid rises.
- Stall: with out_ready low, out_valid, out_data, out_key_idx and out_last hold stable.
- out_valid falls the cycle after the final transfer and the cycle after start.
- Async reset mid-LOAD or mid-STREAM returns all outputs to reset values immediately. load_done stays 0 until a new full load.

## Test plan
- Reset, then default parameters. start, then 176 beats with value = beat number (0x00..0xAF). Required: load_done rises 1 cycle after beat 175; err = 0.
- Forward replay, out_ready = 1. Required: out_data runs 0x00..0xAF in 176 consecutive cycles; out_last on 0x0F, 0x1F, ..., 0xAF; out_key_idx 0..10; state returns to READY.
- Reverse replay (rd_dir = 1). Required: first beats are 0xA0..0xAF with out_key_idx = 10, last beats are 0x00..0x0F with out_key_idx = 0.
- Random out_ready backpressure during reverse replay. Required: no beat lost or duplicated; outputs stable while stalled; second replay is identical.
- Protocol errors. Required: in_valid in READY sets err and the stored data is unchanged; rd_start in LOAD sets err; start clears err; start mid-STREAM drops out_valid the next cycle and load_done falls.
- BUS_W = 32, NUM_KEYS = 15, KEY_W = 128. Required: 60-beat load; forward replay of 60 beats with out_last every 4th beat; async reset asserted mid-replay zeroes out_valid immediately.

Source files
------------

// File: rtl/round_key_buffer.sv
// round_key_buffer: stores the expanded round keys one bus beat at a time, then
// replays them forward or reverse on a valid/ready stream as often as needed.
module round_key_buffer #(
    parameter int KEY_W    = 128,
    parameter int BUS_W    = 8,
    parameter int NUM_KEYS = 11
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [BUS_W-1:0]            in_data,
    input  logic                        rd_start,
    input  logic                        rd_dir,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [BUS_W-1:0]            out_data,
    output logic [$clog2(NUM_KEYS)-1:0] out_key_idx,
    output logic                        out_last,
    output logic                        load_done,
    output logic                        busy,
    output logic                        err
);
    localparam int BEATS = KEY_W / BUS_W;
    localparam int DEPTH = NUM_KEYS * BEATS;
    localparam int AW    = $clog2(DEPTH);
    localparam int KW    = $clog2(NUM_KEYS);
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, READY, STREAM} state_t;

    state_t           r_state;
    logic [BUS_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [KW-1:0]    r_key;
    logic [BW-1:0]    r_beat;
    logic             r_dir;
    logic             r_valid;
    logic             r_last;
    logic             r_load_done;
    logic             r_err;
    logic [BUS_W-1:0] r_data;

    logic [AW-1:0]    w_raddr;
    logic [KW-1:0]    w_nkey;
    logic [KW-1:0]    w_rkey;
    logic [BW-1:0]    w_nbeat;
    logic [BW-1:0]    w_rbeat;
    logic             w_beat_end;
    logic             w_final;
    logic             w_xfer;
    logic             w_wr;

    // Read address is the beat that will be on the bus after this edge:
    // the first beat of the replay in READY, the following beat in STREAM.
    always_comb begin
        w_beat_end = r_beat == BW'(BEATS - 1);
        w_final    = w_beat_end && r_key == (r_dir ? KW'(0) : KW'(NUM_KEYS - 1));
        w_nbeat    = w_beat_end ? '0 : r_beat + BW'(1);
        w_nkey     = !w_beat_end ? r_key : r_dir ? r_key - KW'(1) : r_key + KW'(1);
        w_rkey     = r_state == READY ? (rd_dir ? KW'(NUM_KEYS - 1) : KW'(0)) : w_nkey;
        w_rbeat    = r_state == READY ? '0 : w_nbeat;
        w_raddr    = AW'(w_rkey) * AW'(BEATS) + AW'(w_rbeat);
        w_xfer     = r_valid && out_ready;
        w_wr       = r_state == LOAD && in_valid && !start;
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_key       <= '0;
            r_beat      <= '0;
            r_dir       <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_load_done <= 1'b0;
            r_err       <= 1'b0;
            r_data      <= '0;
        end else if (start) begin
            r_state     <= LOAD;
            r_wr_ptr    <= '0;
            r_load_done <= 1'b0;
            r_err       <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid || rd_start)
                        r_err <= 1'b1;
                end
                LOAD: begin
                    if (rd_start)
                        r_err <= 1'b1;
                    if (in_valid) begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                        if (r_wr_ptr == AW'(DEPTH - 1)) begin
                            r_state     <= READY;
                            r_load_done <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (in_valid)
                        r_err <= 1'b1;
                    if (rd_start) begin
                        r_dir   <= rd_dir;
                        r_key   <= w_rkey;
                        r_beat  <= '0;
                        r_valid <= 1'b1;
                        r_data  <= r_mem[w_raddr];
                        r_last  <= w_rbeat == BW'(BEATS - 1);
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (rd_start || in_valid)
                        r_err <= 1'b1;
                    if (w_xfer) begin
                        if (w_final) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= READY;
                        end else begin
                            r_key  <= w_nkey;
                            r_beat <= w_nbeat;
                            r_data <= r_mem[w_raddr];
                            r_last <= w_nbeat == BW'(BEATS - 1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid   = r_valid;
    assign out_data    = r_data;
    assign out_key_idx = r_key;
    assign out_last    = r_last;
    assign load_done   = r_load_done;
    assign busy        = r_state == LOAD || r_state == STREAM;
    assign err         = r_err;
endmodule

// File: tb/tb_round_key_buffer.sv
// tb_round_key_buffer: directed sequence with random data/backpressure against a
// key-array model, on an 8-bit/11-key instance and a 32-bit/15-key instance.
module tb_round_key_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       a_start = 0, a_in_valid = 0, a_rd_start = 0, a_rd_dir = 0, a_ready = 0;
    logic [7:0] a_in_data = 0;
    logic       a_valid, a_last, a_done, a_busy, a_err;
    logic [7:0] a_data;
    logic [3:0] a_idx;

    logic        b_start = 0, b_in_valid = 0, b_rd_start = 0, b_rd_dir = 0, b_ready = 0;
    logic [31:0] b_in_data = 0;
    logic        b_valid, b_last, b_done, b_busy, b_err;
    logic [31:0] b_data;
    logic [3:0]  b_idx;

    round_key_buffer u_a (
        .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid), .in_data(a_in_data),
        .rd_start(a_rd_start), .rd_dir(a_rd_dir), .out_ready(a_ready), .out_valid(a_valid),
        .out_data(a_data), .out_key_idx(a_idx), .out_last(a_last), .load_done(a_done),
        .busy(a_busy), .err(a_err)
    );

    round_key_buffer #(.KEY_W(128), .BUS_W(32), .NUM_KEYS(15)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
        .rd_start(b_rd_start), .rd_dir(b_rd_dir), .out_ready(b_ready), .out_valid(b_valid),
        .out_data(b_data), .out_key_idx(b_idx), .out_last(b_last), .load_done(b_done),
        .busy(b_busy), .err(b_err)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] ma [176];
    logic [31:0] mb [60];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {out_valid, load_done, busy, err}
    function automatic logic [3:0] st(input bit s);
        return s ? {b_valid, b_done, b_busy, b_err} : {a_valid, a_done, a_busy, a_err};
    endfunction

    // {out_last, out_key_idx, out_data}
    function automatic logic [36:0] beat_of(input bit s);
        return s ? {b_last, b_idx, b_data} : {a_last, a_idx, 24'h0, a_data};
    endfunction

    task automatic drive(input bit s, input logic st_, input logic iv, input logic rs,
                         input logic dir, input logic [31:0] d);
        if (s) begin
            b_start = st_; b_in_valid = iv; b_rd_start = rs; b_rd_dir = dir; b_in_data = d;
        end else begin
            a_start = st_; a_in_valid = iv; a_rd_start = rs; a_rd_dir = dir; a_in_data = d[7:0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input bit s, input bit rnd, input bit inj);
        int n;
        logic [31:0] v;
        n = s ? 60 : 176;
        drive(s, 1, 0, 0, 0, 0);
        tick();
        chk("start_state", 64'(st(s)), 64'(4'b0010));
        for (int i = 0; i < n; i++) begin
            v = rnd ? $urandom : 32'(i);
            if (!s) v[31:8] = '0;
            if (s) mb[i] = v; else ma[i] = v;
            drive(s, 0, 1, inj && i == 0, 0, v);
            if (i == n - 1) chk("before_last_write", 64'(st(s)), 64'({3'b001, inj}));
            tick();
        end
        drive(s, 0, 0, 0, 0, 0);
        chk("load_done", 64'(st(s)), 64'({3'b010, inj}));
    endtask

    task automatic replay(input bit s, input bit dir, input bit bp, input logic e);
        int nk, bt, cyc;
        bit r;
        logic [36:0] q[$];
        nk = s ? 15 : 11;
        bt = s ? 4 : 16;
        cyc = 0;
        for (int j = 0; j < nk; j++) begin
            for (int b = 0; b < bt; b++) begin
                int k;
                k = dir ? nk - 1 - j : j;
                q.push_back({b == bt - 1, 4'(k), s ? mb[k * bt + b] : ma[k * bt + b]});
            end
        end
        drive(s, 0, 0, 1, dir, 0);
        tick();
        drive(s, 0, 0, 0, 0, 0);
        while (q.size() > 0 && cyc < 4000) begin
            r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s) b_ready = r; else a_ready = r;
            chk("stream_state", 64'(st(s)), 64'({3'b111, e}));
            chk("beat", 64'(beat_of(s)), 64'(q[0]));
            tick();
            if (r) q.delete(0);
            cyc++;
        end
        if (s) b_ready = 0; else a_ready = 0;
        chk("beats_left", 64'(q.size()), 64'(0));
        if (!bp) chk("replay_cycles", 64'(cyc), 64'(nk * bt));
        chk("replay_end", 64'(st(s)), 64'({3'b010, e}));
    endtask

    initial begin
        #1000000;
        $fatal(1, "FAIL watchdog timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a_state", 64'(st(0)), 64'(0));
        chk("reset_a_beat", 64'(beat_of(0)), 64'(0));
        chk("reset_b_state", 64'(st(1)), 64'(0));
        chk("reset_b_beat", 64'(beat_of(1)), 64'(0));
        rst = 1'b1;
        tick();

        drive(0, 0, 1, 0, 0, 32'h55);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("idle_in_valid_err", 64'(st(0)), 64'(4'b0001));

        load(0, 0, 0);
        replay(0, 0, 0, 0);
        replay(0, 1, 0, 0);
        replay(0, 1, 1, 0);
        replay(0, 1, 1, 0);

        drive(0, 0, 1, 0, 0, 32'hFF);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("ready_in_valid_err", 64'(st(0)), 64'(4'b0101));
        replay(0, 0, 0, 1);

        load(0, 1, 1);
        replay(0, 1, 1, 1);

        drive(0, 1, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("start_beats_rd_start", 64'(st(0)), 64'(4'b0010));

        load(0, 1, 0);
        drive(0, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        a_ready = 1;
        repeat (5) tick();
        chk("mid_stream_beat", 64'(beat_of(0)), 64'({1'b0, 4'd0, ma[5]}));
        drive(0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        a_ready = 0;
        chk("abort_stream", 64'(st(0)), 64'(4'b0010));

        load(1, 1, 0);
        replay(1, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        b_ready = 1;
        repeat (10) tick();
        chk("b_mid_beat", 64'(beat_of(1)), 64'({1'b0, 4'd2, mb[10]}));
        #2 rst = 1'b0;
        #1;
        chk("async_reset_b_state", 64'(st(1)), 64'(0));
        chk("async_reset_b_beat", 64'(beat_of(1)), 64'(0));
        chk("async_reset_a_state", 64'(st(0)), 64'(0));
        b_ready = 0;
        #20;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("after_reset_b", 64'(st(1)), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
